rat_recovery_ctrl: RTL and testbench

Sequencer and write-port arbiter for the speculative rename table (spec RAT). In normal operation it forwards the two rename-stage RAT writes. On a pipeline flush it takes over both spec RAT write ports and walks the architectural RAT, copying all logical-register mappings back in pairs. Rename is stalled until the copy completes. It sits between the rename stage, the spec RAT write ports and new read ports on the arch RAT.

---
 rtl/rat_recovery_ctrl_pkg.sv | 19 +
 rtl/rat_recovery_ctrl_if.sv | 38 +++
 rtl/rat_recovery_ctrl.sv | 96 +++++++++
 tb/tb_rat_recovery_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rat_recovery_ctrl_pkg.sv
// Shared types and constants for the spec RAT recovery sequencer.
// NUM_LREG logical registers are restored two per cycle. The walk pointer
// indexes register pairs.
package rat_recovery_ctrl_pkg;
  localparam int NUM_LREG = 32;
  localparam int LREG_W   = 5;
  localparam int PREG_W   = 6;
  localparam int WALK_W   = 4;
  localparam logic [WALK_W-1:0] WALK_LAST = WALK_W'(NUM_LREG/2 - 1);

  typedef enum logic {RCV_IDLE, RCV_WALK} rat_rcv_state_t;

  // This type is used for both rename writes and spec RAT write ports.
  typedef struct packed {
    logic              valid;
    logic [LREG_W-1:0] addr;
    logic [PREG_W-1:0] data;
  } rat_wr_t;
endpackage

// File: rtl/rat_recovery_ctrl_if.sv
// Bus bundle around the recovery controller.
// - rn0_*/rn1_*: rename-stage writes (rn0 is older).
// - arch_rd_*: arch RAT read ports. Data is combinational from the address.
// - rat_wr0_*/rat_wr1_*: spec RAT write ports.
// The slave modport is for the controller. The master modport is for the
// surrounding rename/RAT logic.
interface rat_recovery_ctrl_if;
  import rat_recovery_ctrl_pkg::*;

  logic              rn0_wr_valid, rn1_wr_valid;
  logic [LREG_W-1:0] rn0_wr_addr,  rn1_wr_addr;
  logic [PREG_W-1:0] rn0_wr_data,  rn1_wr_data;

  logic [LREG_W-1:0] arch_rd_addr0, arch_rd_addr1;
  logic [PREG_W-1:0] arch_rd_data0, arch_rd_data1;

  logic              rat_wr0_valid, rat_wr1_valid;
  logic [LREG_W-1:0] rat_wr0_addr,  rat_wr1_addr;
  logic [PREG_W-1:0] rat_wr0_data,  rat_wr1_data;

  modport slave (
    input  rn0_wr_valid, rn0_wr_addr, rn0_wr_data,
    input  rn1_wr_valid, rn1_wr_addr, rn1_wr_data,
    input  arch_rd_data0, arch_rd_data1,
    output arch_rd_addr0, arch_rd_addr1,
    output rat_wr0_valid, rat_wr0_addr, rat_wr0_data,
    output rat_wr1_valid, rat_wr1_addr, rat_wr1_data
  );

  modport master (
    output rn0_wr_valid, rn0_wr_addr, rn0_wr_data,
    output rn1_wr_valid, rn1_wr_addr, rn1_wr_data,
    output arch_rd_data0, arch_rd_data1,
    input  arch_rd_addr0, arch_rd_addr1,
    input  rat_wr0_valid, rat_wr0_addr, rat_wr0_data,
    input  rat_wr1_valid, rat_wr1_addr, rat_wr1_data
  );
endinterface

// File: rtl/rat_recovery_ctrl.sv
// Spec RAT write-port arbiter and flush recovery sequencer.
// In IDLE, the two rename writes are forwarded to the spec RAT. If both
// writes target the same address, the younger write wins.
// A flush starts a walk of the arch RAT. The walk copies one register pair
// per cycle into the spec RAT and stalls rename until the copy completes.
// Ports:
//   clock, reset     core clock; reset is asynchronous and active-high
//   flush_valid      pipeline flush (ROB empty afterwards)
//   bus              rename / arch-read / spec-write bundle (slave side)
//   rename_stall     rename holds its group
//   recover_busy     walk in progress
//   recover_done     pulse in the last walk cycle
//   walk_ptr         current register-pair index (debug)
module rat_recovery_ctrl
  import rat_recovery_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_valid,
  rat_recovery_ctrl_if.slave bus,
  output logic              rename_stall,
  output logic              recover_busy,
  output logic              recover_done,
  output logic [WALK_W-1:0] walk_ptr
);

  rat_rcv_state_t    state;
  rat_wr_t           rn0, rn1, wr0, wr1;
  logic [LREG_W-1:0] rd0, rd1;

  assign rn0 = '{valid: bus.rn0_wr_valid, addr: bus.rn0_wr_addr, data: bus.rn0_wr_data};
  assign rn1 = '{valid: bus.rn1_wr_valid, addr: bus.rn1_wr_addr, data: bus.rn1_wr_data};

  // When the walk completes, walk_ptr stays at its last value. It is cleared
  // only by the next flush or by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RCV_IDLE;
      walk_ptr <= '0;
    end else begin
      case (state)
        RCV_IDLE: if (flush_valid) begin
          state    <= RCV_WALK;
          walk_ptr <= '0;
        end
        RCV_WALK: begin
          if (flush_valid)                walk_ptr <= '0;
          else if (walk_ptr == WALK_LAST) state    <= RCV_IDLE;
          else                            walk_ptr <= walk_ptr + 1'b1;
        end
        default: state <= RCV_IDLE;
      endcase
    end
  end

  // The outputs are gated by reset. State returns to IDLE asynchronously,
  // and without the gate IDLE would let the rename inputs through while
  // reset is still asserted.
  always_comb begin
    wr0          = '0;
    wr1          = '0;
    rd0          = '0;
    rd1          = '0;
    rename_stall = 1'b0;
    recover_busy = 1'b0;
    recover_done = 1'b0;
    if (!reset) begin
      if (state == RCV_WALK) begin
        rename_stall = 1'b1;
        recover_busy = 1'b1;
        // A flush during the walk restarts it. That cycle is a bubble with
        // no writes and no done pulse.
        if (!flush_valid) begin
          rd0          = {walk_ptr, 1'b0};
          rd1          = {walk_ptr, 1'b1};
          wr0          = {1'b1, rd0, bus.arch_rd_data0};
          wr1          = {1'b1, rd1, bus.arch_rd_data1};
          recover_done = (walk_ptr == WALK_LAST);
        end
      end else if (flush_valid) begin
        rename_stall = 1'b1;  // the squashed group is dropped
      end else begin
        wr0 = rn0;
        wr1 = rn1;
        if (rn0.valid && rn1.valid && (rn0.addr == rn1.addr))
          wr0.valid = 1'b0;
      end
    end
  end

  assign bus.arch_rd_addr0 = rd0;
  assign bus.arch_rd_addr1 = rd1;
  assign {bus.rat_wr0_valid, bus.rat_wr0_addr, bus.rat_wr0_data} = wr0;
  assign {bus.rat_wr1_valid, bus.rat_wr1_addr, bus.rat_wr1_data} = wr1;

endmodule

// File: tb/tb_rat_recovery_ctrl.sv
// Directed bench for rat_recovery_ctrl. The IDLE vectors come from a table.
// The multi-cycle recovery cases use hand-written sequences against a small
// arch RAT array and a spec RAT model.
module tb_rat_recovery_ctrl;
  import rat_recovery_ctrl_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush_valid;
  logic              rename_stall, recover_busy, recover_done;
  logic [WALK_W-1:0] walk_ptr;

  rat_recovery_ctrl_if bus();

  rat_recovery_ctrl dut (
    .clock(clock), .reset(reset), .flush_valid(flush_valid), .bus(bus),
    .rename_stall(rename_stall), .recover_busy(recover_busy),
    .recover_done(recover_done), .walk_ptr(walk_ptr)
  );

  always #5 clock = ~clock;

  logic [PREG_W-1:0] arch_mem [NUM_LREG];
  logic [PREG_W-1:0] spec_mem [NUM_LREG];

  assign bus.arch_rd_data0 = arch_mem[bus.arch_rd_addr0];
  assign bus.arch_rd_data1 = arch_mem[bus.arch_rd_addr1];

  // Spec RAT model: on a same-cycle collision, port 1 is applied last and wins.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LREG; i++) spec_mem[i] <= PREG_W'(i);
    end else begin
      if (bus.rat_wr0_valid) spec_mem[bus.rat_wr0_addr] <= bus.rat_wr0_data;
      if (bus.rat_wr1_valid) spec_mem[bus.rat_wr1_addr] <= bus.rat_wr1_data;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic v, input logic [LREG_W-1:0] a,
                                     input logic [PREG_W-1:0] d);
    return 32'({v, a, d});
  endfunction

  function automatic logic [31:0] w0();
    return pk(bus.rat_wr0_valid, bus.rat_wr0_addr, bus.rat_wr0_data);
  endfunction

  function automatic logic [31:0] w1();
    return pk(bus.rat_wr1_valid, bus.rat_wr1_addr, bus.rat_wr1_data);
  endfunction

  // Set the inputs just after a falling edge, then wait for the
  // combinational outputs to settle before the next rising edge.
  task automatic drive(input logic fl, input logic [11:0] r0, input logic [11:0] r1);
    @(negedge clock);
    flush_valid = fl;
    {bus.rn0_wr_valid, bus.rn0_wr_addr, bus.rn0_wr_data} = r0;
    {bus.rn1_wr_valid, bus.rn1_wr_addr, bus.rn1_wr_data} = r1;
    #2;
  endtask

  typedef struct {
    string             nm;
    logic [11:0]       r0, r1;
    logic [11:0]       e0, e1;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [LREG_W-1:0] a0, a1;
    int                diffs;

    vecs[0] = '{"pass",      {1'b1,5'd5,6'd40},  {1'b1,5'd7,6'd41},  {1'b1,5'd5,6'd40},  {1'b1,5'd7,6'd41}};
    vecs[1] = '{"conflict",  {1'b1,5'd9,6'd33},  {1'b1,5'd9,6'd34},  {1'b0,5'd9,6'd33},  {1'b1,5'd9,6'd34}};
    vecs[2] = '{"rn0_only",  {1'b1,5'd3,6'd12},  {1'b0,5'd4,6'd13},  {1'b1,5'd3,6'd12},  {1'b0,5'd4,6'd13}};
    vecs[3] = '{"rn1_only",  {1'b0,5'd3,6'd12},  {1'b1,5'd4,6'd13},  {1'b0,5'd3,6'd12},  {1'b1,5'd4,6'd13}};
    vecs[4] = '{"same_inv1", {1'b1,5'd6,6'd20},  {1'b0,5'd6,6'd21},  {1'b1,5'd6,6'd20},  {1'b0,5'd6,6'd21}};
    vecs[5] = '{"x0_x31",    {1'b1,5'd0,6'd63},  {1'b1,5'd31,6'd62}, {1'b1,5'd0,6'd63},  {1'b1,5'd31,6'd62}};
    vecs[6] = '{"none",      {1'b0,5'd2,6'd1},   {1'b0,5'd2,6'd2},   {1'b0,5'd2,6'd1},   {1'b0,5'd2,6'd2}};

    for (int i = 0; i < NUM_LREG; i++) arch_mem[i] = PREG_W'((i + 32) % 64);

    // Reset: hold for 3 cycles with active rename inputs, which must be
    // gated off.
    reset = 1'b1;
    flush_valid = 1'b0;
    {bus.rn0_wr_valid, bus.rn0_wr_addr, bus.rn0_wr_data} = {1'b1,5'd5,6'd40};
    {bus.rn1_wr_valid, bus.rn1_wr_addr, bus.rn1_wr_data} = {1'b1,5'd7,6'd41};
    repeat (3) @(posedge clock);
    #2;
    chk("rst_wr0", w0(), 32'd0);
    chk("rst_wr1", w1(), 32'd0);
    chk("rst_stall", 32'(rename_stall), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 12'd0, 12'd0);
    chk("post_rst_ptr", 32'(walk_ptr), 32'd0);
    chk("post_rst_stall", 32'(rename_stall), 32'd0);
    chk("post_rst_busy", 32'(recover_busy), 32'd0);
    chk("post_rst_done", 32'(recover_done), 32'd0);
    chk("post_rst_rd", 32'({bus.arch_rd_addr0, bus.arch_rd_addr1}), 32'd0);

    // IDLE vectors from the table.
    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].r0, vecs[i].r1);
      chk({vecs[i].nm, "_wr0"}, w0(), 32'(vecs[i].e0));
      chk({vecs[i].nm, "_wr1"}, w1(), 32'(vecs[i].e1));
      chk({vecs[i].nm, "_stall"}, 32'(rename_stall), 32'd0);
    end
    drive(1'b0, 12'd0, 12'd0);
    chk("conflict_x9", 32'(spec_mem[9]), 32'd34);

    // Full walk: no writes in the flush cycle T, one pair per cycle for
    // T+1..T+16, and rename resumes at T+17.
    drive(1'b1, {1'b1,5'd5,6'd11}, {1'b1,5'd6,6'd12});
    chk("T_wr0v", 32'(bus.rat_wr0_valid), 32'd0);
    chk("T_wr1v", 32'(bus.rat_wr1_valid), 32'd0);
    chk("T_stall", 32'(rename_stall), 32'd1);
    chk("T_done", 32'(recover_done), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      drive(1'b0, {1'b1,5'(k),6'(k)}, {1'b1,5'(k+1),6'(k)});
      a0 = 5'(2*k - 2);
      a1 = 5'(2*k - 1);
      chk("walk_wr0", w0(), pk(1'b1, a0, arch_mem[a0]));
      chk("walk_wr1", w1(), pk(1'b1, a1, arch_mem[a1]));
      chk("walk_ptr", 32'(walk_ptr), 32'(k - 1));
      chk("walk_stall", 32'(rename_stall), 32'd1);
      chk("walk_busy", 32'(recover_busy), 32'd1);
      chk("walk_done", 32'(recover_done), 32'(k == 16));
    end
    drive(1'b0, {1'b1,5'd10,6'd50}, {1'b0,5'd11,6'd51});
    diffs = 0;
    for (int i = 0; i < NUM_LREG; i++) if (spec_mem[i] !== arch_mem[i]) diffs++;
    chk("spec_eq_arch", 32'(diffs), 32'd0);
    chk("T17_stall", 32'(rename_stall), 32'd0);
    chk("T17_busy", 32'(recover_busy), 32'd0);
    chk("T17_wr0", w0(), pk(1'b1, 5'd10, 6'd50));
    chk("T17_ptr_hold", 32'(walk_ptr), 32'd15);

    // Re-flush at walk_ptr=9. The walk restarts at pair 0, and there is no
    // done pulse at the original completion time.
    drive(1'b1, 12'd0, 12'd0);
    for (int k = 1; k <= 9; k++) drive(1'b0, 12'd0, 12'd0);
    drive(1'b1, {1'b1,5'd1,6'd1}, {1'b1,5'd2,6'd2});
    chk("reflush_ptr", 32'(walk_ptr), 32'd9);
    chk("reflush_wr0v", 32'(bus.rat_wr0_valid), 32'd0);
    chk("reflush_wr1v", 32'(bus.rat_wr1_valid), 32'd0);
    chk("reflush_done", 32'(recover_done), 32'd0);
    chk("reflush_stall", 32'(rename_stall), 32'd1);
    for (int j = 1; j <= 16; j++) begin
      drive(1'b0, 12'd0, 12'd0);
      a0 = 5'(2*j - 2);
      chk("rewalk_ptr", 32'(walk_ptr), 32'(j - 1));
      chk("rewalk_wr0", w0(), pk(1'b1, a0, arch_mem[a0]));
      chk("rewalk_done", 32'(recover_done), 32'(j == 16));
    end
    drive(1'b0, 12'd0, 12'd0);
    chk("rewalk_end_stall", 32'(rename_stall), 32'd0);

    // A flush at the final pair suppresses done.
    drive(1'b1, 12'd0, 12'd0);
    for (int k = 1; k <= 15; k++) drive(1'b0, 12'd0, 12'd0);
    drive(1'b1, 12'd0, 12'd0);
    chk("maxflush_ptr", 32'(walk_ptr), 32'd15);
    chk("maxflush_done", 32'(recover_done), 32'd0);
    chk("maxflush_wr1v", 32'(bus.rat_wr1_valid), 32'd0);

    // Reset during the walk at walk_ptr=5. The outputs must clear
    // asynchronously, and passthrough must work right after release.
    for (int k = 1; k <= 5; k++) drive(1'b0, 12'd0, 12'd0);
    drive(1'b0, {1'b1,5'd12,6'd44}, {1'b1,5'd13,6'd45});
    chk("pre_rst_ptr", 32'(walk_ptr), 32'd5);
    chk("pre_rst_wr0v", 32'(bus.rat_wr0_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_wr0", w0(), 32'd0);
    chk("arst_wr1", w1(), 32'd0);
    chk("arst_rd", 32'({bus.arch_rd_addr0, bus.arch_rd_addr1}), 32'd0);
    chk("arst_flags", 32'({rename_stall, recover_busy, recover_done}), 32'd0);
    chk("arst_ptr", 32'(walk_ptr), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, {1'b1,5'd12,6'd44}, {1'b1,5'd13,6'd45});
    chk("rel_wr0", w0(), pk(1'b1, 5'd12, 6'd44));
    chk("rel_wr1", w1(), pk(1'b1, 5'd13, 6'd45));
    chk("rel_stall", 32'(rename_stall), 32'd0);
    chk("rel_busy", 32'(recover_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
